// File: rtl/std_shift_reg_n.sv
// N-bit universal shift register: hold, shift right/left, rotate, parallel load,
// with a saturating shift counter and a one-cycle done pulse on reaching N shifts.
module std_shift_reg_n #(
    parameter int            N       = 8,
    parameter logic [N-1:0]  RST_VAL = '0,
    parameter int            CW      = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic          rot,
    input  logic          sin,
    input  logic [N-1:0]  pin,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [1:0]    MODE_HOLD = 2'b00;
    localparam logic [1:0]    MODE_SR   = 2'b01;
    localparam logic [1:0]    MODE_SL   = 2'b10;
    localparam logic [1:0]    MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] CNT_MAX   = CW'(N);
    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);

    logic [N-1:0]  q_r;
    logic [CW-1:0] cnt_r;
    logic          done_r;

    logic          b_right_s;
    logic          b_left_s;
    logic [N-1:0]  shr_s;
    logic [N-1:0]  shl_s;
    logic [N-1:0]  q_next_s;
    logic [CW-1:0] cnt_next_s;
    logic          done_next_s;
    logic          is_shift_s;

    // Wrapped bit replaces sin when rotating, so sin is never sampled then.
    assign b_right_s = rot ? q_r[0]   : sin;
    assign b_left_s  = rot ? q_r[N-1] : sin;

    generate
        if (N == 1) begin : g_one
            assign shr_s = b_right_s;
            assign shl_s = b_left_s;
        end else begin : g_many
            assign shr_s = {b_right_s, q_r[N-1:1]};
            assign shl_s = {q_r[N-2:0], b_left_s};
        end
    endgenerate

    // Next-state selection for register contents, counter and done pulse.
    always_comb begin
        q_next_s    = q_r;
        cnt_next_s  = cnt_r;
        done_next_s = 1'b0;
        is_shift_s  = 1'b0;
        case (mode)
            MODE_HOLD: begin
                q_next_s = q_r;
            end
            MODE_SR: begin
                q_next_s   = shr_s;
                is_shift_s = 1'b1;
            end
            MODE_SL: begin
                q_next_s   = shl_s;
                is_shift_s = 1'b1;
            end
            MODE_LOAD: begin
                q_next_s   = pin;
                cnt_next_s = '0;
            end
            default: begin
                q_next_s = q_r;
            end
        endcase
        if (is_shift_s && (cnt_r < CNT_MAX)) begin
            cnt_next_s  = cnt_r + CW'(1);
            done_next_s = (cnt_r == CNT_LAST);
        end else begin
            done_next_s = 1'b0;
        end
    end

    // State registers; en low holds q/cnt and clears done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_r    <= RST_VAL;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (en) begin
            q_r    <= q_next_s;
            cnt_r  <= cnt_next_s;
            done_r <= done_next_s;
        end else begin
            done_r <= 1'b0;
        end
    end

    assign q    = q_r;
    assign cnt  = cnt_r;
    assign done = done_r;
    // sout shows the bit about to leave in the current direction.
    assign sout = (mode == MODE_SL) ? q_r[N-1] : q_r[0];

endmodule

// File: tb/tb_std_shift_reg_n.sv
// Directed self-checking bench for std_shift_reg_n (N=8 with RST_VAL=A5, and N=1).
module tb_std_shift_reg_n;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [1:0] mode;
    logic       rot;
    logic       sin;
    logic [7:0] pin;
    logic [7:0] q;
    logic       sout;
    logic [3:0] cnt;
    logic       done;

    logic       en1;
    logic [1:0] mode1;
    logic       rot1;
    logic       sin1;
    logic [0:0] pin1;
    logic [0:0] q1;
    logic       sout1;
    logic [0:0] cnt1;
    logic       done1;

    int n_cmp;
    int n_err;

    std_shift_reg_n #(.N(8), .RST_VAL(8'hA5)) dut8 (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode), .rot(rot), .sin(sin),
        .pin(pin), .q(q), .sout(sout), .cnt(cnt), .done(done)
    );

    std_shift_reg_n #(.N(1), .RST_VAL(1'b0)) dut1 (
        .clk(clk), .rstn(rstn), .en(en1), .mode(mode1), .rot(rot1), .sin(sin1),
        .pin(pin1), .q(q1), .sout(sout1), .cnt(cnt1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic r,
                        input logic s, input logic [7:0] p);
        en = e; mode = m; rot = r; sin = s; pin = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rstn = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0; sin = 1'b0; pin = 8'h00;
        en1 = 1'b0; mode1 = 2'b00; rot1 = 1'b0; sin1 = 1'b0; pin1 = 1'b0;
        #12;
        check("rst_q", q, 8'hA5);
        check("rst_cnt", cnt, 4'd0);
        check("rst_done", done, 1'b0);
        check("rst_q1", q1, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Load 81 then shift right with sin=0
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
        check("ld_q", q, 8'h81);
        check("ld_cnt", cnt, 4'd0);
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; mode = 2'b01; rot = 1'b0; sin = 1'b0; #1;
            check($sformatf("sr_sout%0d", i), sout, (i == 0 || i == 7) ? 1'b1 : 1'b0);
            step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            check($sformatf("sr_done%0d", i), done, (i == 7) ? 1'b1 : 1'b0);
        end
        check("sr_q", q, 8'h00);
        check("sr_cnt", cnt, 4'd8);
        step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        check("sr9_cnt", cnt, 4'd8);
        check("sr9_done", done, 1'b0);

        // Rotate left from 81
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
        mode = 2'b10; #1;
        check("sl_sout", sout, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b10, 1'b1, 1'b0, 8'h00);
            check($sformatf("rl_done%0d", i), done, (i == 7) ? 1'b1 : 1'b0);
            if (i == 3) check("rl_q4", q, 8'h18);
        end
        check("rl_q8", q, 8'h81);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        check("hold_q", q, 8'h81);
        check("hold_done", done, 1'b0);

        // Enable gating
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h0F);
        step(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
        check("en1_q", q, 8'h87);
        step(1'b0, 2'b01, 1'b0, 1'b1, 8'h00);
        check("en0_q", q, 8'h87);
        check("en0_done", done, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
        check("en2_q", q, 8'hC3);
        step(1'b0, 2'b01, 1'b0, 1'b1, 8'h00);
        check("en3_q", q, 8'hC3);
        check("en_cnt", cnt, 4'd2);
        check("en_done", done, 1'b0);

        // Load priority over the final shift
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        check("pr_cnt7", cnt, 4'd7);
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
        check("pr_q", q, 8'h3C);
        check("pr_cnt", cnt, 4'd0);
        check("pr_done", done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            check($sformatf("pr_done%0d", i), done, (i == 7) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset mid-run
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
        step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        #2 rstn = 1'b0;
        #1;
        check("arst_q", q, 8'hA5);
        check("arst_cnt", cnt, 4'd0);
        check("arst_done", done, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        step(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
        check("post_q", q, 8'hD2);
        check("post_cnt", cnt, 4'd1);

        // N=1 instance
        en = 1'b0;
        en1 = 1'b1; mode1 = 2'b11; pin1 = 1'b1;
        @(posedge clk); #1;
        check("n1_ld_q", q1, 1'b1);
        mode1 = 2'b01; sin1 = 1'b0; rot1 = 1'b0;
        @(posedge clk); #1;
        check("n1_sr_q", q1, 1'b0);
        check("n1_sr_cnt", cnt1, 1'b1);
        check("n1_sr_done", done1, 1'b1);
        rot1 = 1'b1; sin1 = 1'b1;
        @(posedge clk); #1;
        check("n1_rot_q", q1, 1'b0);
        check("n1_rot_cnt", cnt1, 1'b1);
        check("n1_rot_done", done1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
